flag_cond_unit: RTL and testbench

- Consumer side of the ALU flag interface: captures the negative/zero/overflow/carry_flag outputs of the ALU into an architectural NZCV register whenever a flag-setting instruction writes back.
- Evaluates ARM condition codes for B.cond on behalf of the decode/branch stage.
- Tracks in-flight flag-setting instructions and stalls condition queries until their flags are valid.

---
 rtl/flag_pkg.sv | 40 ++++
 rtl/cond_eval.sv | 32 +++
 rtl/flag_cond_unit.sv | 146 ++++++++++++++
 tb/tb_flag_cond_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - shared condition-code, NZCV and FSM types for flag_cond_unit
package flag_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HS = 4'b0010,
        COND_LO = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    localparam int IDX_N = 3;
    localparam int IDX_Z = 2;
    localparam int IDX_C = 1;
    localparam int IDX_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluator
module cond_eval
    import flag_pkg::*;
(
    input  cond_e cond,
    input  nzcv_t flags,
    output logic  taken
);

    // Decode the condition field against the supplied NZCV; AL and NV are unconditional.
    always_comb begin
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = flags.z;
            COND_NE: taken = !flags.z;
            COND_HS: taken = flags.c;
            COND_LO: taken = !flags.c;
            COND_MI: taken = flags.n;
            COND_PL: taken = !flags.n;
            COND_VS: taken = flags.v;
            COND_VC: taken = !flags.v;
            COND_HI: taken = flags.c && !flags.z;
            COND_LS: taken = !flags.c || flags.z;
            COND_GE: taken = (flags.n == flags.v);
            COND_LT: taken = (flags.n != flags.v);
            COND_GT: taken = !flags.z && (flags.n == flags.v);
            COND_LE: taken = flags.z || (flags.n != flags.v);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - NZCV register, pending tracker and B.cond query FSM (option: FLAG_FWD_EN)
module flag_cond_unit
    import flag_pkg::*;
#(
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flag_issue,
    input  logic       flag_wr_en,
    input  logic       negative,
    input  logic       zero,
    input  logic       carry_flag,
    input  logic       overflow,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       resp_valid,
    output logic       cond_taken,
    output logic [3:0] flags_out,
    output logic       pend_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    nzcv_t            nzcv_q, nzcv_d;
    cond_e            code_q, code_d;
    logic             pend_err_q, pend_err_d;
    logic             resp_valid_q, resp_valid_d;
    logic             cond_taken_q, cond_taken_d;

    logic [3:0]       alu_vec;
    nzcv_t            alu_nzcv;
    nzcv_t            fwd_nzcv;
    logic [CNT_W-1:0] eff;
    logic             eval_en;
    cond_e            eval_code;
    logic             eval_taken;

    // Pack the ALU flag outputs into NZCV order.
    always_comb begin
        alu_vec        = 4'b0000;
        alu_vec[IDX_N] = negative;
        alu_vec[IDX_Z] = zero;
        alu_vec[IDX_C] = carry_flag;
        alu_vec[IDX_V] = overflow;
        alu_nzcv       = nzcv_t'(alu_vec);
    end

    // Effective pending count and flags seen by a query; a flag_issue this cycle is younger and ignored.
    always_comb begin
`ifdef FLAG_FWD_EN
        fwd_nzcv = flag_wr_en ? alu_nzcv : nzcv_q;
        eff      = (flag_wr_en && (pending_q != '0)) ? pending_q - CNT_W'(1) : pending_q;
`else
        fwd_nzcv = nzcv_q;
        eff      = pending_q;
`endif
    end

    // Architectural flag register and pending counter with sticky over/underflow error.
    always_comb begin
        nzcv_d     = flag_wr_en ? alu_nzcv : nzcv_q;
        pending_d  = pending_q;
        pend_err_d = pend_err_q;
        if (flag_issue && !flag_wr_en) begin
            if (pending_q == CNT_W'(MAX_PENDING)) begin
                pend_err_d = 1'b1;
            end else begin
                pending_d = pending_q + CNT_W'(1);
            end
        end else if (flag_wr_en && !flag_issue) begin
            if (pending_q == '0) begin
                pend_err_d = 1'b1;
            end else begin
                pending_d = pending_q - CNT_W'(1);
            end
        end
    end

    // Query FSM: answer immediately when no older flag writer is outstanding, else park in WAIT.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        eval_en   = 1'b0;
        eval_code = code_q;
        case (state_q)
            ST_IDLE: begin
                if (cond_valid) begin
                    if (eff == '0) begin
                        eval_en   = 1'b1;
                        eval_code = cond_e'(cond_code);
                    end else begin
                        code_d  = cond_e'(cond_code);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (eff == '0) begin
                    eval_en   = 1'b1;
                    eval_code = code_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        resp_valid_d = eval_en;
        cond_taken_d = eval_en ? eval_taken : cond_taken_q;
    end

    cond_eval u_cond_eval (
        .cond  (eval_code),
        .flags (fwd_nzcv),
        .taken (eval_taken)
    );

    // State registers; reset drops any parked query.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            nzcv_q       <= '0;
            code_q       <= COND_EQ;
            pend_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            cond_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            nzcv_q       <= nzcv_d;
            code_q       <= code_d;
            pend_err_q   <= pend_err_d;
            resp_valid_q <= resp_valid_d;
            cond_taken_q <= cond_taken_d;
        end
    end

    assign cond_ready = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign cond_taken = cond_taken_q;
    assign flags_out  = nzcv_q;
    assign pend_err   = pend_err_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// tb/tb_flag_cond_unit.sv - directed table-driven bench for flag_cond_unit (option: FLAG_FWD_EN)
module tb_flag_cond_unit;

    logic       clk;
    logic       reset_n;
    logic       flag_issue;
    logic       flag_wr_en;
    logic       negative;
    logic       zero;
    logic       carry_flag;
    logic       overflow;
    logic       cond_valid;
    logic [3:0] cond_code;
    logic       cond_ready;
    logic       resp_valid;
    logic       cond_taken;
    logic [3:0] flags_out;
    logic       pend_err;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] code;
        logic [3:0] nzcv;
        logic       exp;
    } vec_t;

    vec_t vecs[18];

    flag_cond_unit #(.MAX_PENDING(3), .CNT_W(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flag_issue (flag_issue),
        .flag_wr_en (flag_wr_en),
        .negative   (negative),
        .zero       (zero),
        .carry_flag (carry_flag),
        .overflow   (overflow),
        .cond_valid (cond_valid),
        .cond_code  (cond_code),
        .cond_ready (cond_ready),
        .resp_valid (resp_valid),
        .cond_taken (cond_taken),
        .flags_out  (flags_out),
        .pend_err   (pend_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        negative   = f[3];
        zero       = f[2];
        carry_flag = f[1];
        overflow   = f[0];
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        flag_issue = 1'b0;
        flag_wr_en = 1'b0;
        cond_valid = 1'b0;
        cond_code  = 4'h0;
        set_flags(4'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Wait (bounded) for resp_valid; returns 1 if seen.
    task automatic wait_resp(input int limit, output logic seen, output int cycles);
        seen   = resp_valid;
        cycles = 0;
        while (!seen && cycles < limit) begin
            tick();
            cycles++;
            seen = resp_valid;
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf & !z;
            4'h9: return !cf | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // One flag-setting instruction issues, then retires with f while a query for code arrives.
    task automatic run_vec(input string name, input logic [3:0] code, input logic [3:0] f, input logic exp);
        logic seen;
        int   cyc;
        flag_issue = 1'b1;
        tick();
        flag_issue = 1'b0;
        flag_wr_en = 1'b1;
        set_flags(f);
        cond_valid = 1'b1;
        cond_code  = code;
        tick();
        flag_wr_en = 1'b0;
        cond_valid = 1'b0;
        wait_resp(4, seen, cyc);
        chk({name, "_resp"}, {7'd0, seen}, 8'd1);
        chk({name, "_taken"}, {7'd0, cond_taken}, {7'd0, exp});
        chk({name, "_flags"}, {4'd0, flags_out}, {4'd0, f});
        tick();
    endtask

    initial begin
        logic seen;
        int   cyc;
        checks = 0;
        errors = 0;

        vecs[0]  = '{4'h0, 4'b0100, 1'b1};
        vecs[1]  = '{4'h1, 4'b0100, 1'b0};
        vecs[2]  = '{4'h2, 4'b0010, 1'b1};
        vecs[3]  = '{4'h3, 4'b0010, 1'b0};
        vecs[4]  = '{4'h4, 4'b1000, 1'b1};
        vecs[5]  = '{4'h5, 4'b1000, 1'b0};
        vecs[6]  = '{4'h6, 4'b0001, 1'b1};
        vecs[7]  = '{4'h7, 4'b0000, 1'b1};
        vecs[8]  = '{4'h8, 4'b0010, 1'b1};
        vecs[9]  = '{4'h8, 4'b0110, 1'b0};
        vecs[10] = '{4'h9, 4'b0110, 1'b1};
        vecs[11] = '{4'hA, 4'b1001, 1'b1};
        vecs[12] = '{4'hB, 4'b1000, 1'b1};
        vecs[13] = '{4'hC, 4'b0000, 1'b1};
        vecs[14] = '{4'hC, 4'b0100, 1'b0};
        vecs[15] = '{4'hD, 4'b0001, 1'b1};
        vecs[16] = '{4'hE, 4'b0000, 1'b1};
        vecs[17] = '{4'hF, 4'b0000, 1'b1};

        // Reset values while reset is held.
        reset_n    = 1'b0;
        flag_issue = 1'b0;
        flag_wr_en = 1'b0;
        cond_valid = 1'b0;
        cond_code  = 4'h0;
        set_flags(4'h0);
        #2;
        chk("rst_flags", {4'd0, flags_out}, 8'h00);
        chk("rst_resp", {7'd0, resp_valid}, 8'd0);
        chk("rst_taken", {7'd0, cond_taken}, 8'd0);
        chk("rst_err", {7'd0, pend_err}, 8'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_ready", {7'd0, cond_ready}, 8'd1);

        // EQ with nothing pending answers one cycle later.
        cond_valid = 1'b1;
        cond_code  = 4'h0;
        tick();
        cond_valid = 1'b0;
        chk("eq_resp", {7'd0, resp_valid}, 8'd1);
        chk("eq_taken", {7'd0, cond_taken}, 8'd0);
        chk("eq_flags", {4'd0, flags_out}, 8'h00);
        tick();
        chk("eq_resp_drop", {7'd0, resp_valid}, 8'd0);

        // LT queried in the same cycle the N=1 flags retire.
        flag_issue = 1'b1;
        tick();
        flag_issue = 1'b0;
        flag_wr_en = 1'b1;
        set_flags(4'b1000);
        cond_valid = 1'b1;
        cond_code  = 4'hB;
        tick();
        flag_wr_en = 1'b0;
        cond_valid = 1'b0;
`ifdef FLAG_FWD_EN
        chk("lt_resp", {7'd0, resp_valid}, 8'd1);
        chk("lt_taken", {7'd0, cond_taken}, 8'd1);
        chk("lt_ready", {7'd0, cond_ready}, 8'd1);
`else
        chk("lt_resp_early", {7'd0, resp_valid}, 8'd0);
        chk("lt_ready_wait", {7'd0, cond_ready}, 8'd0);
        tick();
        chk("lt_resp", {7'd0, resp_valid}, 8'd1);
        chk("lt_taken", {7'd0, cond_taken}, 8'd1);
`endif
        tick();
        chk("lt_err", {7'd0, pend_err}, 8'd0);

        // Two issues in flight, then GT; must wait for the second retirement.
        flag_issue = 1'b1;
        tick();
        tick();
        flag_issue = 1'b0;
        cond_valid = 1'b1;
        cond_code  = 4'hC;
        tick();
        cond_valid = 1'b0;
        chk("gt_ready_low", {7'd0, cond_ready}, 8'd0);
        flag_wr_en = 1'b1;
        set_flags(4'b1000);
        tick();
        chk("gt_no_early", {7'd0, resp_valid}, 8'd0);
        set_flags(4'b0000);
        tick();
        flag_wr_en = 1'b0;
        wait_resp(3, seen, cyc);
        chk("gt_resp", {7'd0, seen}, 8'd1);
`ifdef FLAG_FWD_EN
        chk("gt_latency", cyc[7:0], 8'd0);
`else
        chk("gt_latency", cyc[7:0], 8'd1);
`endif
        chk("gt_taken", {7'd0, cond_taken}, 8'd1);
        chk("gt_ready_back", {7'd0, cond_ready}, 8'd1);
        tick();

        // Saturation: four issues, then three retirements must clear a parked query.
        do_reset();
        flag_issue = 1'b1;
        repeat (4) tick();
        flag_issue = 1'b0;
        chk("sat_err", {7'd0, pend_err}, 8'd1);
        cond_valid = 1'b1;
        cond_code  = 4'hE;
        tick();
        cond_valid = 1'b0;
        flag_wr_en = 1'b1;
        set_flags(4'b0000);
        tick();
        tick();
        chk("sat_still_wait", {7'd0, cond_ready}, 8'd0);
        tick();
        flag_wr_en = 1'b0;
        wait_resp(3, seen, cyc);
        chk("sat_resp", {7'd0, seen}, 8'd1);
        chk("sat_taken", {7'd0, cond_taken}, 8'd1);
        tick();

        // Underflow: retirement with nothing pending still writes flags.
        do_reset();
        flag_wr_en = 1'b1;
        set_flags(4'b1010);
        tick();
        flag_wr_en = 1'b0;
        chk("unf_err", {7'd0, pend_err}, 8'd1);
        chk("unf_flags", {4'd0, flags_out}, 8'h0A);

        // Hand-computed decode table.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("tab%0d", i), vecs[i].code, vecs[i].nzcv, vecs[i].exp);
        end

        // Full sweep of all codes over all flag values.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                run_vec($sformatf("sw_c%0d_f%0d", c, f), 4'(c), 4'(f), ref_cond(4'(c), 4'(f)));
            end
        end
        chk("sweep_err", {7'd0, pend_err}, 8'd0);

        // Reset while a query is parked in WAIT.
        flag_issue = 1'b1;
        tick();
        flag_issue = 1'b0;
        cond_valid = 1'b1;
        cond_code  = 4'h1;
        tick();
        cond_valid = 1'b0;
        chk("rw_wait", {7'd0, cond_ready}, 8'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rw_ready", {7'd0, cond_ready}, 8'd1);
        chk("rw_flags", {4'd0, flags_out}, 8'h00);
        chk("rw_resp", {7'd0, resp_valid}, 8'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rw_no_resp", {7'd0, resp_valid}, 8'd0);
        cond_valid = 1'b1;
        cond_code  = 4'h1;
        tick();
        cond_valid = 1'b0;
        chk("rw_new_resp", {7'd0, resp_valid}, 8'd1);
        chk("rw_new_taken", {7'd0, cond_taken}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
